// File: rtl/pingpong_multiport_sram.sv
`default_nettype none
// ============================================================================
// Module   : pingpong_multiport_sram
// Brief    : Double-buffered multi-port SRAM. Writers fill the back bank while
//            readers scan the front bank. A handshaked flip can clear the new
//            back bank in the background.
// Revision : 1.0  initial release
// ============================================================================
module pingpong_multiport_sram #(
  parameter int                 NUM_WR  = 1,
  parameter int                 NUM_RD  = 4,
  parameter int                 ADDR_W  = 12,
  parameter int                 DATA_W  = 1,
  parameter int                 DEPTH   = 4096,
  parameter logic [DATA_W-1:0]  CLR_VAL = '0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_WR-1:0]         write_enables,
  input  logic [NUM_WR*DATA_W-1:0]  data_ins,
  input  logic [NUM_WR*ADDR_W-1:0]  write_addrs,
  input  logic [NUM_RD*ADDR_W-1:0]  read_addrs,
  output logic [NUM_RD*DATA_W-1:0]  data_outs,
  input  logic                      flip_req,
  input  logic                      clear_en,
  output logic                      busy,
  output logic                      flip_done,
  output logic                      front_sel,
  output logic                      wr_collision
);

  localparam int                CNT_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0]   DEPTH_X  = (ADDR_W + 1)'(DEPTH);
  localparam logic [CNT_W-1:0]  LAST_IDX = CNT_W'(DEPTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t                   state_q,        state_d;
  logic                     front_sel_q,    front_sel_d;
  logic [CNT_W-1:0]         clr_cnt_q,      clr_cnt_d;
  logic                     wr_collision_q, wr_collision_d;
  logic [NUM_RD*DATA_W-1:0] data_outs_q,    data_outs_d;

  logic [DATA_W-1:0]        mem_q [0:1][0:DEPTH-1];

  logic                     w_busy;
  logic                     w_back_sel;
  logic [NUM_WR-1:0]        w_wr_valid;
  logic [NUM_WR-1:0]        w_wr_win;

  function automatic logic in_range(input logic [ADDR_W-1:0] addr);
    return ({1'b0, addr} < DEPTH_X);
  endfunction

  assign w_busy     = (state_q == ST_CLEAR);
  assign w_back_sel = ~front_sel_q;

  // Writes are only eligible outside CLEAR and inside the bank.
  always_comb begin
    w_wr_valid = '0;
    for (int i = 0; i < NUM_WR; i++) begin
      w_wr_valid[i] = write_enables[i] && !w_busy
                      && in_range(write_addrs[i*ADDR_W +: ADDR_W]);
    end
  end

  // A writer loses if any lower-indexed valid writer targets the same word.
  always_comb begin
    w_wr_win       = w_wr_valid;
    wr_collision_d = 1'b0;
    for (int i = 1; i < NUM_WR; i++) begin
      for (int j = 0; j < i; j++) begin
        if (w_wr_valid[i] && w_wr_valid[j]
            && (write_addrs[i*ADDR_W +: ADDR_W] == write_addrs[j*ADDR_W +: ADDR_W])) begin
          w_wr_win[i]    = 1'b0;
          wr_collision_d = 1'b1;
        end
      end
    end
  end

  always_comb begin
    data_outs_d = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      if (in_range(read_addrs[i*ADDR_W +: ADDR_W])) begin
        data_outs_d[i*DATA_W +: DATA_W] =
          mem_q[front_sel_q][CNT_W'(read_addrs[i*ADDR_W +: ADDR_W])];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    front_sel_d = front_sel_q;
    clr_cnt_d   = clr_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (flip_req) begin
          front_sel_d = ~front_sel_q;
          clr_cnt_d   = '0;
          state_d     = clear_en ? ST_CLEAR : ST_DONE;
        end
      end
      ST_CLEAR: begin
        clr_cnt_d = clr_cnt_q + CNT_W'(1);
        if (clr_cnt_q == LAST_IDX) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      front_sel_q    <= 1'b0;
      clr_cnt_q      <= '0;
      wr_collision_q <= 1'b0;
      data_outs_q    <= '0;
    end else begin
      state_q        <= state_d;
      front_sel_q    <= front_sel_d;
      clr_cnt_q      <= clr_cnt_d;
      wr_collision_q <= wr_collision_d;
      data_outs_q    <= data_outs_d;
    end
  end

  // Storage is deliberately not reset; clear and user writes never overlap.
  always_ff @(posedge clk) begin
    if (state_q == ST_CLEAR) begin
      mem_q[w_back_sel][clr_cnt_q] <= CLR_VAL;
    end
    for (int i = 0; i < NUM_WR; i++) begin
      if (w_wr_win[i]) begin
        mem_q[w_back_sel][CNT_W'(write_addrs[i*ADDR_W +: ADDR_W])] <=
          data_ins[i*DATA_W +: DATA_W];
      end
    end
  end

  assign data_outs    = data_outs_q;
  assign busy         = w_busy;
  assign flip_done    = (state_q == ST_DONE);
  assign front_sel    = front_sel_q;
  assign wr_collision = wr_collision_q;

endmodule
`default_nettype wire

// File: tb/tb_pingpong_multiport_sram.sv
`default_nettype none
// ============================================================================
// Module   : tb_pingpong_multiport_sram
// Brief    : Directed self-checking bench for pingpong_multiport_sram.
// Revision : 1.0  initial release
// ============================================================================
module tb_pingpong_multiport_sram;

  localparam int NUM_WR = 2;
  localparam int NUM_RD = 2;
  localparam int ADDR_W = 5;
  localparam int DATA_W = 4;
  localparam int DEPTH  = 16;
  localparam int CLR    = 'hA;

  logic                      clk = 1'b0;
  logic                      rst = 1'b1;
  logic [NUM_WR-1:0]         write_enables;
  logic [NUM_WR*DATA_W-1:0]  data_ins;
  logic [NUM_WR*ADDR_W-1:0]  write_addrs;
  logic [NUM_RD*ADDR_W-1:0]  read_addrs;
  logic [NUM_RD*DATA_W-1:0]  data_outs;
  logic                      flip_req;
  logic                      clear_en;
  logic                      busy;
  logic                      flip_done;
  logic                      front_sel;
  logic                      wr_collision;

  int n_cmp = 0;
  int n_bad = 0;
  int n;

  pingpong_multiport_sram #(
    .NUM_WR  (NUM_WR),
    .NUM_RD  (NUM_RD),
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .DEPTH   (DEPTH),
    .CLR_VAL (4'hA)
  ) u_dut (
    .clk           (clk),
    .rst           (rst),
    .write_enables (write_enables),
    .data_ins      (data_ins),
    .write_addrs   (write_addrs),
    .read_addrs    (read_addrs),
    .data_outs     (data_outs),
    .flip_req      (flip_req),
    .clear_en      (clear_en),
    .busy          (busy),
    .flip_done     (flip_done),
    .front_sel     (front_sel),
    .wr_collision  (wr_collision)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int ch, input int a, input int d);
    write_enables[ch]               = 1'b1;
    write_addrs[ch*ADDR_W +: ADDR_W] = ADDR_W'(a);
    data_ins[ch*DATA_W +: DATA_W]    = DATA_W'(d);
  endtask

  task automatic rd(input int ch, input int a);
    read_addrs[ch*ADDR_W +: ADDR_W] = ADDR_W'(a);
  endtask

  function automatic logic [DATA_W-1:0] dout(input int ch);
    return data_outs[ch*DATA_W +: DATA_W];
  endfunction

  initial begin
    write_enables = '0;
    data_ins      = '0;
    write_addrs   = '0;
    read_addrs    = '0;
    flip_req      = 1'b0;
    clear_en      = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_dout",  32'(data_outs),    0);
    check("rst_busy",  32'(busy),         0);
    check("rst_done",  32'(flip_done),    0);
    check("rst_front", 32'(front_sel),    0);
    check("rst_coll",  32'(wr_collision), 0);
    rst = 1'b0;
    step();

    // Basic write, flip without clear, read back from the new front.
    wr(0, 5, 1);
    step();
    write_enables = '0;
    flip_req = 1'b1;
    step();
    flip_req = 1'b0;
    check("t1_front", 32'(front_sel), 1);
    check("t1_done",  32'(flip_done), 1);
    check("t1_busy",  32'(busy),      0);
    wr(0, 9, 'hC);
    rd(0, 5);
    rd(1, 16);
    step();
    write_enables = '0;
    check("t1_rd5",        32'(dout(0)),   1);
    check("t1_rd_oor",     32'(dout(1)),   0);
    check("t1_done_pulse", 32'(flip_done), 0);

    // Same-address collision, then distinct addresses.
    wr(0, 3, 7);
    wr(1, 3, 9);
    step();
    write_enables = '0;
    check("t2_coll", 32'(wr_collision), 1);
    wr(0, 4, 2);
    wr(1, 6, 6);
    step();
    write_enables = '0;
    check("t2_no_coll", 32'(wr_collision), 0);
    flip_req = 1'b1;
    step();
    flip_req = 1'b0;
    check("t2_front", 32'(front_sel), 0);
    rd(0, 3);
    rd(1, 6);
    step();
    check("t2_rd3", 32'(dout(0)), 7);
    check("t2_rd6", 32'(dout(1)), 6);
    rd(0, 4);
    rd(1, 9);
    step();
    check("t2_rd4",      32'(dout(0)), 2);
    check("t2_rd9_done", 32'(dout(1)), 'hC);

    // Fill back bank, flip with clear, probe ignored requests during CLEAR.
    for (int k = 0; k < 8; k++) begin
      wr(0, 2*k, 'hF);
      wr(1, 2*k + 1, 'hF);
      step();
    end
    write_enables = '0;
    rd(0, 0);
    rd(1, 2);
    flip_req = 1'b1;
    clear_en = 1'b1;
    step();
    flip_req = 1'b0;
    clear_en = 1'b0;
    check("t3_front", 32'(front_sel), 1);
    check("t3_busy",  32'(busy),      1);
    n = 0;
    while (busy && n < 40) begin
      if (n == 3) begin
        flip_req = 1'b1;
        wr(0, 2, 3);
      end else begin
        flip_req = 1'b0;
        write_enables = '0;
      end
      step();
      n++;
      if (n == 6) begin
        check("t3_front_rd",   32'(dout(0)),   'hF);
        check("t3_front_hold", 32'(front_sel), 1);
      end
    end
    flip_req = 1'b0;
    write_enables = '0;
    check("t3_busy_cycles", 32'(n),         16);
    check("t3_done",        32'(flip_done), 1);
    check("t3_front_after", 32'(front_sel), 1);
    flip_req = 1'b1;
    step();
    flip_req = 1'b0;
    check("t3_done_req_ign", 32'(front_sel), 1);
    check("t3_done_once",    32'(flip_done), 0);
    flip_req = 1'b1;
    step();
    flip_req = 1'b0;
    check("t3_front2", 32'(front_sel), 0);
    for (int k = 0; k < 8; k++) begin
      rd(0, 2*k);
      rd(1, 2*k + 1);
      step();
      check("t3_clr_even", 32'(dout(0)), CLR);
      check("t3_clr_odd",  32'(dout(1)), CLR);
    end

    // Out-of-range write and read.
    wr(0, 16, 5);
    rd(1, 16);
    step();
    write_enables = '0;
    check("t4_rd_oor", 32'(dout(1)), 0);
    flip_req = 1'b1;
    step();
    flip_req = 1'b0;
    rd(0, 0);
    step();
    check("t4_front", 32'(front_sel), 1);
    check("t4_rd0",   32'(dout(0)),   'hF);
    check("t4_oor2",  32'(dout(1)),   0);

    // Reset in the middle of a clear.
    rd(0, 0);
    flip_req = 1'b1;
    clear_en = 1'b1;
    step();
    flip_req = 1'b0;
    clear_en = 1'b0;
    repeat (5) step();
    check("t5_busy", 32'(busy),      1);
    check("t5_rd0",  32'(dout(0)),   CLR);
    check("t5_front", 32'(front_sel), 0);
    #2;
    rst = 1'b1;
    #1;
    check("t5_rst_dout",  32'(data_outs),    0);
    check("t5_rst_busy",  32'(busy),         0);
    check("t5_rst_done",  32'(flip_done),    0);
    check("t5_rst_front", 32'(front_sel),    0);
    check("t5_rst_coll",  32'(wr_collision), 0);
    step();
    rst = 1'b0;
    step();
    check("t5_idle_busy", 32'(busy), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
